// File: rtl/buffer_pkg.sv
// buffer_pkg: shared definitions for the buffer streamer slice.
//   ADDR_W_DEF : default buffer address width (buffer depth = 2**ADDR_W bytes)
//   DEPTH_DEF  : default buffer depth in bytes
//   BYTE_W     : width of a stream / memory byte
//   state_e    : sequencing states of the streamer
//   sum8       : modulo-256 byte accumulator step used by the optional checksum
package buffer_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] val);
        return acc + val;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: two-entry byte FIFO used to prefetch buffer bytes for the engine.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous flush (drops all entries)
//   push/din : write one byte (ignored when full unless a pop happens in the same cycle)
//   pop/dout : remove head byte (ignored when empty); dout is the current head
//   full, empty, count : occupancy status
module stream_fifo2
    import buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [BYTE_W-1:0] data0_q, data0_d;
    logic [BYTE_W-1:0] data1_q, data1_d;
    logic              wr_idx_q, wr_idx_d;
    logic              rd_idx_q, rd_idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_push_s, do_pop_s;

    // Next-state logic: push into the write slot, pop from the read slot, track occupancy.
    always_comb begin
        do_pop_s  = pop & (cnt_q != 2'd0);
        do_push_s = push & ((cnt_q != 2'd2) | do_pop_s);
        data0_d   = data0_q;
        data1_d   = data1_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        cnt_d     = cnt_q;
        if (clr) begin
            wr_idx_d = 1'b0;
            rd_idx_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (do_push_s) begin
                if (wr_idx_q) begin
                    data1_d = din;
                end else begin
                    data0_d = din;
                end
                wr_idx_d = ~wr_idx_q;
            end else begin
                wr_idx_d = wr_idx_q;
            end
            if (do_pop_s) begin
                rd_idx_d = ~rd_idx_q;
            end else begin
                rd_idx_d = rd_idx_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data0_q  <= 8'h00;
            data1_q  <= 8'h00;
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = rd_idx_q ? data1_q : data0_q;
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/buffer_streamer.sv
// buffer_streamer: streams a full input buffer from memory port b into an encode
// engine and writes the engine's output back into the same buffer.
//   clk, rst             : clock, synchronous active-high reset
//   start                : request to process the buffer (accepted only when idle)
//   sel_o                : buffer ownership, 1 while the streamer owns port b
//   mem_addr/wdata/rdata/cs/we : memory port b (1-cycle synchronous read)
//   in_data/valid/ready  : byte stream towards the engine, in address order
//   out_data/valid/last/ready : byte stream from the engine, written from address 0
//   done                 : one-cycle completion pulse
//   out_len              : number of bytes actually written to memory
//   err                  : engine output exceeded the buffer
// Optional feature: define BUFFER_STREAMER_CHKSUM_EN to add output chksum, the
// modulo-256 sum of all bytes written to memory during the last run.
module buffer_streamer
    import buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              sel_o,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [7:0]        in_data,
    output logic              in_valid,
    input  logic              in_ready,
    input  logic [7:0]        out_data,
    input  logic              out_valid,
    input  logic              out_last,
    output logic              out_ready,
    output logic              done,
    output logic [ADDR_W:0]   out_len,
    output logic              err
`ifdef BUFFER_STREAMER_CHKSUM_EN
    ,
    output logic [7:0]        chksum
`endif
);

    // Pointers carry one extra bit so "reached depth" is distinct from address 0.
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_e          state_q, state_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] out_len_q, out_len_d;
    logic            err_q, err_d;
    logic            rd_pend_q, rd_pend_d;

    logic            run_s, wr_acc_s, wr_issue_s, rd_issue_s;
    logic [2:0]      occ_s;
    logic            fifo_push_s, fifo_pop_s, fifo_clr_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [1:0]      fifo_count_s;
    logic [7:0]      fifo_dout_s;

    // Port b arbitration: an engine write wins; a read is issued only while the
    // prefetch FIFO plus the outstanding read leave room for its data.
    always_comb begin
        run_s      = (state_q == ST_RUN);
        wr_acc_s   = run_s & out_valid;
        wr_issue_s = wr_acc_s & ~wr_ptr_q[ADDR_W];
        occ_s      = {1'b0, fifo_count_s} + {2'b00, rd_pend_q};
        rd_issue_s = run_s & ~wr_issue_s & ~rd_ptr_q[ADDR_W] & ~fifo_full_s & (occ_s < 3'd2);
    end

    // Memory port b drive; held quiet during reset so an aborted run stops immediately.
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = rd_ptr_q[ADDR_W-1:0];
        mem_wdata = out_data;
        if (rst) begin
            mem_cs = 1'b0;
            mem_we = 1'b0;
        end else if (wr_issue_s) begin
            mem_cs   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = wr_ptr_q[ADDR_W-1:0];
        end else if (rd_issue_s) begin
            mem_cs = 1'b1;
            mem_we = 1'b0;
        end else begin
            mem_cs = 1'b0;
            mem_we = 1'b0;
        end
    end

    // Sequencing and pointer updates.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        out_len_d = out_len_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    rd_ptr_d  = {(ADDR_W+1){1'b0}};
                    wr_ptr_d  = {(ADDR_W+1){1'b0}};
                    out_len_d = {(ADDR_W+1){1'b0}};
                    err_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (wr_issue_s) begin
                    wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    out_len_d = out_len_q + PTR_ONE;
                    // Filling the last byte while the engine still has more to send.
                    if ((wr_ptr_q == PTR_LAST) && !out_last) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                if (rd_issue_s) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                if (wr_acc_s && out_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A read issued in the final RUN cycle is dropped along with the FIFO.
        rd_pend_d = rd_issue_s & (state_d == ST_RUN);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= {(ADDR_W+1){1'b0}};
            wr_ptr_q  <= {(ADDR_W+1){1'b0}};
            out_len_q <= {(ADDR_W+1){1'b0}};
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            out_len_q <= out_len_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign fifo_push_s = rd_pend_q & run_s;
    assign fifo_pop_s  = ~fifo_empty_s & in_ready;
    assign fifo_clr_s  = run_s & (state_d != ST_RUN);

    stream_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr_s),
        .push  (fifo_push_s),
        .din   (mem_rdata),
        .pop   (fifo_pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign in_valid  = ~fifo_empty_s;
    assign in_data   = fifo_dout_s;
    assign sel_o     = run_s;
    assign out_ready = run_s;
    assign done      = (state_q == ST_DONE);
    assign out_len   = out_len_q;
    assign err       = err_q;

`ifdef BUFFER_STREAMER_CHKSUM_EN
    logic [7:0] chksum_q, chksum_d;

    // Running sum of bytes written to memory; restarts on an accepted start.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            chksum_d = 8'h00;
        end else if (wr_issue_s) begin
            chksum_d = sum8(chksum_q, out_data);
        end else begin
            chksum_d = chksum_q;
        end
    end

    // Checksum register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chksum_q <= 8'h00;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_buffer_streamer.sv
// tb_buffer_streamer: scoreboard bench for buffer_streamer. A memory model and an
// engine model drive the DUT; expected in-stream bytes and memory writes are queued
// when a scenario is launched and a monitor pops and compares them as they appear.
module tb_buffer_streamer;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          sel_o;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_cs;
    logic          mem_we;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          done;
    logic [AW:0]   out_len;
    logic          err;
`ifdef BUFFER_STREAMER_CHKSUM_EN
    logic [7:0]    chksum;
`endif

    buffer_streamer #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel_o     (sel_o),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (done),
        .out_len   (out_len),
        .err       (err)
`ifdef BUFFER_STREAMER_CHKSUM_EN
        ,
        .chksum    (chksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [7:0]    exp_in [$];
    logic [AW-1:0] exp_wa [$];
    logic [7:0]    exp_wd [$];
    logic [7:0]    mon_e;
    logic [AW-1:0] mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Memory unit port b model: synchronous write, 1-cycle read latency.
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;
    logic       do_init;
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
        end else if (mem_cs && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_cs && !mem_we) rdata_q <= mem[mem_addr];
    end
    assign mem_rdata = rdata_q;

    // Engine model. mode 0: idle, 1: identity (echo consumed bytes), 2: generator.
    int         eng_mode = 0;
    int         eng_total = 0;
    int         eng_sent = 0;
    bit         eng_gaps = 0;
    bit         eng_inc = 0;
    logic [7:0] eng_q [$];

    initial begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        forever begin
            @(negedge clk);
            in_ready = (eng_mode == 1) && (!eng_gaps || ($urandom_range(0, 1) == 1));
            if (eng_sent < eng_total &&
                ((eng_mode == 1 && eng_q.size() > 0) || eng_mode == 2) &&
                (!eng_gaps || ($urandom_range(0, 3) != 0))) begin
                out_valid = 1'b1;
                out_data  = (eng_mode == 1) ? eng_q[0] : (eng_inc ? 8'(eng_sent) : 8'hA5);
                out_last  = (eng_sent == eng_total - 1);
            end else begin
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
            #4;
            if (in_valid && in_ready) eng_q.push_back(in_data);
            if (out_valid && out_ready) begin
                if (eng_mode == 1) void'(eng_q.pop_front());
                eng_sent++;
            end
        end
    end

    // Monitor: compares every in-stream handshake and memory write with the queues.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mem_cs) chk("cs_only_in_run", 32'(sel_o), 32'd1);
            if (in_valid && in_ready) begin
                checks++;
                if (exp_in.size() == 0) begin
                    errors++;
                    $display("FAIL in_stream: got byte %0d, none expected", in_data);
                end else begin
                    checks--;
                    mon_e = exp_in.pop_front();
                    chk("in_stream", 32'(in_data), 32'(mon_e));
                end
            end
            if (mem_cs && mem_we) begin
                checks++;
                if (exp_wa.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write: got write addr %0d, none expected", mem_addr);
                end else begin
                    checks--;
                    mon_a = exp_wa.pop_front();
                    mon_e = exp_wd.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(mon_a));
                    chk("write_data", 32'(mem_wdata), 32'(mon_e));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic setup_engine(input int mode, input int total, input bit gaps, input bit inc);
        eng_q.delete();
        eng_sent  = 0;
        eng_total = total;
        eng_gaps  = gaps;
        eng_inc   = inc;
        eng_mode  = mode;
    endtask

    task automatic clear_expect();
        exp_in.delete();
        exp_wa.delete();
        exp_wd.delete();
    endtask

    task automatic push_in_ramp(input int n);
        for (int i = 0; i < n; i++) exp_in.push_back(8'(i));
    endtask

    task automatic push_writes(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            exp_wa.push_back(AW'(i));
            exp_wd.push_back(ramp ? 8'(i) : 8'hA5);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    bit found;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        do_init = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_sel_o", 32'(sel_o), 32'd0);
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        chk("rst_out_ready", 32'(out_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_len", 32'(out_len), 32'd0);
`ifdef BUFFER_STREAMER_CHKSUM_EN
        chk("rst_chksum", 32'(chksum), 32'd0);
`endif
        do_init = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        // S1: identity engine over the full buffer, with a start pulse mid-run.
        clear_expect();
        push_in_ramp(DEPTH);
        push_writes(DEPTH, 1'b1);
        setup_engine(1, DEPTH, 1'b0, 1'b0);
        done_cnt = 0;
        pulse_start();
        #2;
        chk("s1_sel_after_start", 32'(sel_o), 32'd1);
        repeat (500) @(negedge clk);
        pulse_start();
        wait_done("s1", 6000);
        chk("s1_out_len", 32'(out_len), 32'd1024);
        chk("s1_err", 32'(err), 32'd0);
        chk("s1_sel_in_done", 32'(sel_o), 32'd0);
        repeat (3) @(negedge clk);
        chk("s1_done_pulses", 32'(done_cnt), 32'd1);
        chk("s1_out_len_held", 32'(out_len), 32'd1024);
        chk("s1_in_left", 32'(exp_in.size()), 32'd0);
        chk("s1_writes_left", 32'(exp_wa.size()), 32'd0);
`ifdef BUFFER_STREAMER_CHKSUM_EN
        chk("s1_chksum", 32'(chksum), 32'h00);
`endif
        eng_mode = 0;

        // S2: random in_ready and out_valid gaps, 200 bytes echoed.
        clear_expect();
        push_in_ramp(DEPTH);
        push_writes(200, 1'b1);
        setup_engine(1, 200, 1'b1, 1'b0);
        done_cnt = 0;
        pulse_start();
        wait_done("s2", 4000);
        chk("s2_out_len", 32'(out_len), 32'd200);
        chk("s2_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        eng_mode = 0;
        chk("s2_done_pulses", 32'(done_cnt), 32'd1);
        chk("s2_writes_left", 32'(exp_wa.size()), 32'd0);
`ifdef BUFFER_STREAMER_CHKSUM_EN
        chk("s2_chksum", 32'(chksum), 32'hBC);
`endif

        // S3: reset while reading address 300, then a fresh run from address 0.
        clear_expect();
        push_in_ramp(DEPTH);
        push_writes(DEPTH, 1'b1);
        setup_engine(1, DEPTH, 1'b0, 1'b0);
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            #2;
            if (mem_cs && !mem_we && (mem_addr == 10'd300)) found = 1'b1;
        end
        chk("s3_reached_300", 32'(found), 32'd1);
        rst      = 1'b1;
        eng_mode = 0;
        @(negedge clk);
        #2;
        chk("s3_rst_sel_o", 32'(sel_o), 32'd0);
        chk("s3_rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("s3_rst_in_valid", 32'(in_valid), 32'd0);
        chk("s3_rst_out_ready", 32'(out_ready), 32'd0);
        chk("s3_rst_out_len", 32'(out_len), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_expect();
        push_in_ramp(DEPTH);
        push_writes(16, 1'b1);
        setup_engine(1, 16, 1'b0, 1'b0);
        done_cnt = 0;
        pulse_start();
        wait_done("s3", 2000);
        chk("s3_out_len", 32'(out_len), 32'd16);
        repeat (3) @(negedge clk);
        eng_mode = 0;
        chk("s3_done_pulses", 32'(done_cnt), 32'd1);
        chk("s3_writes_left", 32'(exp_wa.size()), 32'd0);

        // S4: engine emits 0xA5 five times without consuming input.
        clear_expect();
        push_writes(5, 1'b0);
        setup_engine(2, 5, 1'b0, 1'b0);
        done_cnt = 0;
        pulse_start();
        wait_done("s4", 500);
        chk("s4_out_len", 32'(out_len), 32'd5);
        chk("s4_err", 32'(err), 32'd0);
        chk("s4_sel_in_done", 32'(sel_o), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #2;
            chk("s4_cs_after_done", 32'(mem_cs), 32'd0);
            chk("s4_sel_after_done", 32'(sel_o), 32'd0);
        end
        eng_mode = 0;
        chk("s4_done_pulses", 32'(done_cnt), 32'd1);
        chk("s4_writes_left", 32'(exp_wa.size()), 32'd0);
`ifdef BUFFER_STREAMER_CHKSUM_EN
        chk("s4_chksum", 32'(chksum), 32'h39);
`endif

        // S5: engine emits 1030 bytes; only the first 1024 may reach memory.
        clear_expect();
        push_writes(DEPTH, 1'b1);
        setup_engine(2, 1030, 1'b0, 1'b1);
        done_cnt = 0;
        pulse_start();
        wait_done("s5", 3000);
        chk("s5_err", 32'(err), 32'd1);
        chk("s5_out_len", 32'(out_len), 32'd1024);
        repeat (3) @(negedge clk);
        eng_mode = 0;
        chk("s5_done_pulses", 32'(done_cnt), 32'd1);
        chk("s5_writes_left", 32'(exp_wa.size()), 32'd0);
        chk("s5_err_held", 32'(err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffer_streamer.md
BUFFER_STREAMER -- requirements
Module: buffer_streamer

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, buffer address width; buffer depth = 2**ADDR_W bytes.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to process a full input buffer (driven by the memory unit's flag_o).
REQ-005 SHALL have port: sel_o  output  1  buffer ownership to memory unit; 1 = engine side (port b).
REQ-006 SHALL have ports: mem_addr  output  ADDR_W, mem_wdata  output  8, mem_rdata  input  8, mem_cs  output  1, mem_we  output  1  memory unit port b.
REQ-007 SHALL have ports: in_data  output  8, in_valid  output  1, in_ready  input  1  byte stream to encode engine.
REQ-008 SHALL have ports: out_data  input  8, out_valid  input  1, out_last  input  1, out_ready  output  1  byte stream from encode engine.
REQ-009 SHALL have ports: done  output  1  one-cycle completion pulse; out_len  output  ADDR_W+1  bytes written; err  output  1  output overflow.

Function
REQ-010 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-011 IDLE: start=1 SHALL move to RUN; rd_ptr, wr_ptr, out_len, err cleared in same transition.
REQ-012 start SHALL be ignored outside IDLE.
REQ-013 sel_o SHALL be 1 exactly while in RUN, asserted the cycle after start is accepted.
REQ-014 Port b SHALL carry at most one access per cycle; write has priority over read.
REQ-015 out_ready SHALL be 1 in RUN, 0 otherwise; out_valid&out_ready SHALL drive mem_cs=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=out_data, wr_ptr++.
REQ-016 Read SHALL issue (mem_cs=1, mem_we=0, mem_addr=rd_ptr, rd_ptr++) when in RUN, no write this cycle, rd_ptr < depth, and prefetch occupancy + in-flight reads < 2.
REQ-017 mem_rdata SHALL be captured into a 2-entry prefetch FIFO the cycle after the read issue (1-cycle synchronous read latency).
REQ-018 in_valid SHALL equal FIFO non-empty; in_data SHALL be FIFO head; in_valid&in_ready pops one entry; bytes SHALL be delivered in address order with no loss or duplication.
REQ-019 in_valid SHALL not depend combinationally on in_ready; out_ready SHALL not depend on out_valid.
REQ-020 mem_cs SHALL be 0 in IDLE and DONE.
REQ-021 Write with out_last=1 SHALL move RUN -> DONE regardless of remaining input; unread input bytes and FIFO contents discarded.
REQ-022 Overflow: write accepted with wr_ptr == depth-1 and out_last=0 SHALL set err=1; subsequent writes SHALL be accepted (out_ready=1) but not issued to memory; wr_ptr SHALL never wrap.
REQ-023 out_len SHALL count memory writes actually issued (max 2**ADDR_W) and hold its value until the next accepted start.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.

Reset
REQ-025 rst SHALL force IDLE, sel_o=0, mem_cs=0, mem_we=0, in_valid=0, out_ready=0, done=0, err=0, out_len=0, pointers 0, FIFO empty; reset mid-RUN SHALL take effect next edge with no further memory access.

Configuration
REQ-026 With BUFFER_STREAMER_CHKSUM_EN defined, module SHALL add port chksum output 8: modulo-256 sum of all bytes written to memory, cleared on accepted start, held after DONE, reset to 0.
REQ-027 Without BUFFER_STREAMER_CHKSUM_EN, port chksum and its adder SHALL be absent.

Structure
REQ-028 Package buffer_pkg SHALL hold ADDR_W default, depth constant, and the FSM state enum.
REQ-029 Prefetch FIFO SHALL be sub-module stream_fifo2 (2 entries, 8 bits, push/pop/full/empty).

Verification
REQ-030 Identity engine, input byte[i]=i[7:0], 1024 bytes, last on 1024th -> output buffer equals input, out_len=1024, err=0, one done pulse.
REQ-031 Random in_ready (50%) and out_valid gaps -> byte order preserved, no duplicates, mem_cs never asserted for read and write in the same cycle.
REQ-032 Engine emits 0xA5 x5 with last on 5th -> out_len=5, done one cycle later, sel_o=0 after DONE, rd_ptr stops.
REQ-033 Engine emits 1030 bytes, last on 1030th -> err=1, out_len=1024, mem_addr never wraps to 0 for a write.
REQ-034 rst asserted at rd_ptr=300 -> next cycle IDLE, sel_o=0, mem_cs=0; new start then processes from address 0.
REQ-035 start pulsed during RUN -> ignored, pointers unaffected; with BUFFER_STREAMER_CHKSUM_EN, scenario REQ-030 -> chksum=0x00 (sum 0..255 x4 mod 256).
